wb_led_pwm_controller: RTL and testbench

Parametrised Wishbone LED controller for NUM_LEDS channels, with per-channel manual, blink and PWM-brightness modes.
- Keeps the existing OUT/TOGGLE/CLEAR/SET word map at 0x00–0x0C.
- Adds mode masks, a shared prescaler, a blink timer and per-channel duty registers.
- Sits as a slave on the SPI-bridged Wishbone bus; drives board LEDs directly.

---
 rtl/wb_led_pwm_controller_if.sv | 27 ++
 rtl/wb_led_pwm_controller.sv | 186 ++++++++++++++++++
 tb/tb_wb_led_pwm_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_led_pwm_controller_if.sv
// Wishbone slave bus bundle for the LED/PWM controller.
interface wb_led_pwm_controller_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   wbs_adr_i;
    logic [DATA_WIDTH-1:0]   wbs_dat_i;
    logic [DATA_WIDTH-1:0]   wbs_dat_o;
    logic                    wbs_we_i;
    logic [SELECT_WIDTH-1:0] wbs_sel_i;
    logic                    wbs_stb_i;
    logic                    wbs_cyc_i;
    logic                    wbs_ack_o;
    logic                    wbs_err_o;
    logic                    wbs_rty_o;

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/wb_led_pwm_controller.sv
// Wishbone LED controller with per-channel manual, blink and PWM modes.
// Define WB_LED_ERR_EN to answer unmapped accesses with err instead of ack.
module wb_led_pwm_controller #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned NUM_LEDS       = 8,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_led_pwm_controller_if.slave wb,
    output logic [NUM_LEDS-1:0]   led_out
);

    localparam int unsigned BLINK_WIDTH = 16;
    localparam int unsigned DUTY_BASE   = 16;
    localparam logic [DATA_WIDTH-1:0] UNMAPPED_DATA = DATA_WIDTH'(32'hDEADBEEF);

    logic [NUM_LEDS-1:0]       out_q;
    logic [NUM_LEDS-1:0]       blink_en_q;
    logic [NUM_LEDS-1:0]       pwm_en_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_q;
    logic [BLINK_WIDTH-1:0]    blink_period_q;
    logic [BLINK_WIDTH-1:0]    blink_cnt_q;
    logic                      blink_phase_q;
    logic [PWM_BITS-1:0]       pwm_cnt_q;
    logic [PWM_BITS-1:0]       duty_q [NUM_LEDS];
    logic                      ack_q;
    logic                      err_q;
    logic [DATA_WIDTH-1:0]     dat_q;

    logic [5:0]            word_c;
    logic                  start_c;
    logic                  wr_c;
    logic                  tick_c;
    logic                  mapped_c;
    logic [DATA_WIDTH-1:0] rd_c;
    logic [DATA_WIDTH-1:0] wmask_c;
    logic [DATA_WIDTH-1:0] wdat_c;
    logic [NUM_LEDS-1:0]   lmask_c;
    logic [NUM_LEDS-1:0]   ldat_c;
    logic [NUM_LEDS-1:0]   pwm_on_c;
    logic [NUM_LEDS-1:0]   led_next_c;
    logic                  unused_bits_c;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_err_o = err_q;
    assign wb.wbs_rty_o = 1'b0;
    assign wb.wbs_dat_o = dat_q;

    assign word_c  = wb.wbs_adr_i[7:2];
    assign start_c = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q & ~err_q;
    assign wr_c    = start_c & wb.wbs_we_i & mapped_c;
    assign tick_c  = (pre_cnt_q == prescale_q);
    assign unused_bits_c = ^{wb.wbs_adr_i[ADDR_WIDTH-1:8], wb.wbs_adr_i[1:0],
                             wb.wbs_dat_i, wmask_c, wdat_c};

    // Byte-lane write mask; every writable register merges through it
    always_comb begin
        wmask_c = '0;
        for (int k = 0; k < int'(SELECT_WIDTH); k++) begin
            wmask_c[k*8 +: 8] = {8{wb.wbs_sel_i[k]}};
        end
        wdat_c  = wb.wbs_dat_i & wmask_c;
        lmask_c = wmask_c[NUM_LEDS-1:0];
        ldat_c  = wdat_c[NUM_LEDS-1:0];
    end

    // Read decode; TOGGLE/CLEAR/SET alias OUT on reads
    always_comb begin
        rd_c     = '0;
        mapped_c = 1'b1;
        case (word_c)
            6'd0, 6'd1, 6'd2, 6'd3: rd_c[NUM_LEDS-1:0] = out_q;
            6'd4: rd_c[NUM_LEDS-1:0]       = blink_en_q;
            6'd5: rd_c[NUM_LEDS-1:0]       = pwm_en_q;
            6'd6: rd_c[PRESCALE_WIDTH-1:0] = prescale_q;
            6'd7: rd_c[BLINK_WIDTH-1:0]    = blink_period_q;
            6'd8: begin
                rd_c[0]    = blink_phase_q;
                rd_c[15:8] = 8'(NUM_LEDS);
            end
            default: begin
                mapped_c = 1'b0;
                for (int i = 0; i < int'(NUM_LEDS); i++) begin
                    if (word_c == 6'(DUTY_BASE + i)) begin
                        mapped_c = 1'b1;
                        rd_c[PWM_BITS-1:0] = duty_q[i];
                    end
                end
            end
        endcase
    end

    // PWM has priority over blink, blink gates the manual value
    always_comb begin
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            pwm_on_c[i]   = (pwm_cnt_q < duty_q[i]);
            led_next_c[i] = pwm_en_q[i]   ? pwm_on_c[i] :
                            blink_en_q[i] ? (out_q[i] & blink_phase_q) : out_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q          <= '0;
            blink_en_q     <= '0;
            pwm_en_q       <= '0;
            prescale_q     <= '0;
            pre_cnt_q      <= '0;
            blink_period_q <= BLINK_WIDTH'(16'h00FF);
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            pwm_cnt_q      <= '0;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            dat_q          <= '0;
            led_out        <= '0;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;

            if (start_c) begin
`ifdef WB_LED_ERR_EN
                if (mapped_c) begin
                    ack_q <= 1'b1;
                    if (!wb.wbs_we_i) dat_q <= rd_c;
                end else begin
                    err_q <= 1'b1;
                    dat_q <= '0;
                end
`else
                ack_q <= 1'b1;
                if (!wb.wbs_we_i) dat_q <= mapped_c ? rd_c : UNMAPPED_DATA;
`endif
            end

            // Timebase: prescaler, PWM ramp and blink phase all advance on tick
            if (tick_c) begin
                pre_cnt_q <= '0;
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
                if (blink_cnt_q >= blink_period_q) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end else begin
                pre_cnt_q <= pre_cnt_q + 1'b1;
            end

            if (wr_c) begin
                case (word_c)
                    6'd0: out_q <= (out_q & ~lmask_c) | ldat_c;
                    6'd1: out_q <= out_q ^ ldat_c;
                    6'd2: out_q <= out_q & ~ldat_c;
                    6'd3: out_q <= out_q | ldat_c;
                    6'd4: blink_en_q <= (blink_en_q & ~lmask_c) | ldat_c;
                    6'd5: pwm_en_q   <= (pwm_en_q & ~lmask_c) | ldat_c;
                    6'd6: begin
                        prescale_q <= (prescale_q & ~wmask_c[PRESCALE_WIDTH-1:0])
                                      | wdat_c[PRESCALE_WIDTH-1:0];
                        pre_cnt_q  <= '0;
                    end
                    6'd7: blink_period_q <= (blink_period_q & ~wmask_c[BLINK_WIDTH-1:0])
                                            | wdat_c[BLINK_WIDTH-1:0];
                    default: ;
                endcase
                for (int i = 0; i < int'(NUM_LEDS); i++) begin
                    if (word_c == 6'(DUTY_BASE + i)) begin
                        duty_q[i] <= (duty_q[i] & ~wmask_c[PWM_BITS-1:0]) | wdat_c[PWM_BITS-1:0];
                    end
                end
            end

            led_out <= led_next_c;
        end
    end

endmodule

// File: tb/tb_wb_led_pwm_controller.sv
// Directed self-checking bench for wb_led_pwm_controller (NUM_LEDS=8, PWM_BITS=8).
module tb_wb_led_pwm_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led_out;

    int errors = 0;
    int checks = 0;

    wb_led_pwm_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4)) wb ();

    wb_led_pwm_controller #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
        .NUM_LEDS(8), .PWM_BITS(8), .PRESCALE_WIDTH(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wb     (wb),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_access(input logic [31:0] addr, input logic write, input logic [31:0] data,
                              input logic [3:0] sel, output logic [31:0] rdata,
                              output logic got_ack, output logic got_err);
        int n;
        @(posedge clk); #1;
        wb.wbs_adr_i = addr;
        wb.wbs_dat_i = data;
        wb.wbs_we_i  = write;
        wb.wbs_sel_i = sel;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        n = 0;
        while (!(wb.wbs_ack_o || wb.wbs_err_o) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 8) check("bus_timeout", 32'(n), 32'd0);
        got_ack = wb.wbs_ack_o;
        got_err = wb.wbs_err_o;
        rdata   = wb.wbs_dat_o;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] d;
        logic a, e;
        bus_access(addr, 1'b1, data, sel, d, a, e);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
        logic a, e;
        bus_access(addr, 1'b0, 32'h0, 4'hF, data, a, e);
    endtask

    // Counts cycles until led_out[1] changes; returns 99 if it never does
    task automatic wait_led1_change(output int n);
        logic v;
        v = led_out[1];
        n = 99;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (led_out[1] !== v) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        a, e;
        int          hi, n;

        rst = 1'b1;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 32'(led_out), 32'h0);
        check("reset_ack", 32'(wb.wbs_ack_o), 32'h0);
        rst = 1'b0;

        wb_read(32'h00, rd); check("rd_out_reset", rd, 32'h0);
        wb_read(32'h1C, rd); check("rd_period_reset", rd, 32'h0000_00FF);
        wb_read(32'h20, rd); check("rd_status_reset", rd, 32'h0000_0800);

        // Word map: OUT write then W1 toggle/clear/set
        wb_write(32'h00, 32'h0000_00A5, 4'hF);
        @(posedge clk); #1; check("led_after_out", 32'(led_out), 32'hA5);
        wb_read(32'h00, rd); check("rd_out_a5", rd, 32'hA5);
        wb_write(32'h04, 32'h0000_000F, 4'hF);
        @(posedge clk); #1; check("led_after_toggle", 32'(led_out), 32'hAA);
        wb_read(32'h04, rd); check("rd_toggle_alias", rd, 32'hAA);
        wb_write(32'h08, 32'h0000_0080, 4'hF);
        @(posedge clk); #1; check("led_after_clear", 32'(led_out), 32'h2A);
        wb_read(32'h08, rd); check("rd_clear_alias", rd, 32'h2A);
        wb_write(32'h0C, 32'h0000_0002, 4'hF);
        @(posedge clk); #1; check("led_after_set", 32'(led_out), 32'h2A);
        wb_read(32'h0C, rd); check("rd_set_alias", rd, 32'h2A);

        // Duty register truncates to PWM_BITS
        wb_write(32'h5C, 32'h0000_01FF, 4'hF);
        wb_read(32'h5C, rd); check("rd_duty7_trunc", rd, 32'hFF);

        // PWM at full rate
        wb_write(32'h18, 32'h0, 4'hF);
        wb_write(32'h14, 32'h01, 4'hF);
        wb_write(32'h40, 32'd64, 4'hF);
        repeat (3) @(posedge clk);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            @(posedge clk); #1;
            if (led_out[0]) hi++;
        end
        check("pwm_duty64_count", 32'(hi), 32'd64);
        wb_write(32'h40, 32'd0, 4'hF);
        repeat (3) @(posedge clk);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            @(posedge clk); #1;
            if (led_out[0]) hi++;
        end
        check("pwm_duty0_count", 32'(hi), 32'd0);
        wb_write(32'h14, 32'h00, 4'hF);

        // Blink on channel 1: tick every 2 cycles, period 3 -> half-period 8 cycles
        wb_write(32'h18, 32'd1, 4'hF);
        wb_write(32'h1C, 32'd3, 4'hF);
        wb_write(32'h10, 32'h02, 4'hF);
        wb_write(32'h00, 32'h02, 4'hF);
        wait_led1_change(n);
        wait_led1_change(n); check("blink_half_period_a", 32'(n), 32'd8);
        wait_led1_change(n); check("blink_half_period_b", 32'(n), 32'd8);
        wb_read(32'h20, rd); check("status_phase_a", 32'(rd[0]), 32'(led_out[1]));
        wait_led1_change(n);
        wb_read(32'h20, rd); check("status_phase_b", 32'(rd[0]), 32'(led_out[1]));
        wb_write(32'h10, 32'h00, 4'hF);

        // Byte lanes: only lane 0 lands; lane 1 has no bits in OUT
        wb_write(32'h00, 32'hFFFF_FF12, 4'b0001);
        wb_read(32'h00, rd); check("sel_lane0", rd, 32'h12);
        wb_write(32'h00, 32'h0000_FFFF, 4'b0010);
        wb_read(32'h00, rd); check("sel_lane1_noeffect", rd, 32'h12);
        wb_write(32'h1C, 32'h0000_AB00, 4'b0010);
        wb_read(32'h1C, rd); check("sel_period_hi", rd, 32'hAB03);

        // Held strobe: one ack every 2 cycles
        @(posedge clk); #1;
        wb.wbs_adr_i = 32'h00;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        hi = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) hi++;
        end
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        check("held_stb_acks", 32'(hi), 32'd3);

        // Unmapped accesses
        bus_access(32'h3C, 1'b0, 32'h0, 4'hF, rd, a, e);
`ifdef WB_LED_ERR_EN
        check("unmapped_3c_data", rd, 32'h0);
        check("unmapped_3c_ack", 32'(a), 32'h0);
        check("unmapped_3c_err", 32'(e), 32'h1);
`else
        check("unmapped_3c_data", rd, 32'hDEADBEEF);
        check("unmapped_3c_ack", 32'(a), 32'h1);
        check("unmapped_3c_err", 32'(e), 32'h0);
`endif
        bus_access(32'h60, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, a, e);
`ifdef WB_LED_ERR_EN
        check("unmapped_60_err", 32'(e), 32'h1);
`else
        check("unmapped_60_ack", 32'(a), 32'h1);
`endif
        wb_read(32'h00, rd); check("unmapped_wr_dropped", rd, 32'h12);

        // Reset during a pending write
        @(posedge clk); #1;
        rst = 1'b1;
        wb.wbs_adr_i = 32'h00;
        wb.wbs_dat_i = 32'h55;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ack", 32'(wb.wbs_ack_o), 32'h0);
        @(posedge clk); #1;
        check("rst_mid_ack2", 32'(wb.wbs_ack_o), 32'h0);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        rst = 1'b0;
        check("rst_led", 32'(led_out), 32'h0);
        wb_read(32'h00, rd); check("rst_out", rd, 32'h0);
        wb_read(32'h18, rd); check("rst_prescale", rd, 32'h0);
        wb_read(32'h1C, rd); check("rst_period", rd, 32'h00FF);
        wb_read(32'h5C, rd); check("rst_duty7", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
